// File: rtl/tensor_operand_collector_pkg.sv
// Shared encodings and default sizes for the tensor-core operand collector.
package tensor_operand_collector_pkg;

  localparam int unsigned NUM_THREAD = 4;
  localparam int unsigned DEPTH_WARP = 3;

  localparam logic [1:0] OPD_SEL_A   = 2'd0;
  localparam logic [1:0] OPD_SEL_B   = 2'd1;
  localparam logic [1:0] OPD_SEL_C   = 2'd2;
  localparam logic [1:0] OPD_SEL_ILL = 2'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_ISSUE   = 2'd2;

endpackage

// File: rtl/tensor_operand_collector_opd_reg.sv
// One operand vector register with write enable and synchronous reset.
module tc_opd_reg #(
  parameter int unsigned DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (we_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/tensor_operand_collector.sv
// Collects A/B/C operand beats for one tensor op and hands the set to the
// FP32 tensor core over a single valid/ready handshake.
module tensor_operand_collector
  import tensor_operand_collector_pkg::*;
#(
  parameter int unsigned VL        = NUM_THREAD,
  parameter int unsigned EXPWIDTH  = 8,
  parameter int unsigned PRECISION = 24,
  parameter int unsigned WARPW     = DEPTH_WARP
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [WARPW-1:0]                 req_warpid_i,
  input  logic [7:0]                       req_reg_idxw_i,
  input  logic [2:0]                       req_rm_i,
  input  logic                             opd_valid_i,
  output logic                             opd_ready_o,
  input  logic [1:0]                       opd_sel_i,
  input  logic [VL*(EXPWIDTH+PRECISION)-1:0] opd_data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [VL*(EXPWIDTH+PRECISION)-1:0] a_o,
  output logic [VL*(EXPWIDTH+PRECISION)-1:0] b_o,
  output logic [VL*(EXPWIDTH+PRECISION)-1:0] c_o,
  output logic [VL*3-1:0]                  rm_o,
  output logic [7:0]                       ctrl_reg_idxw_o,
  output logic [WARPW-1:0]                 ctrl_warpid_o,
  output logic                             err_o
);

  localparam int unsigned W  = EXPWIDTH + PRECISION;
  localparam int unsigned DW = VL * W;

  logic [1:0]       state_q, state_d;
  logic [2:0]       got_q, got_d;
  logic             err_q, err_d;
  logic [WARPW-1:0] warp_q, warp_d;
  logic [7:0]       idx_q, idx_d;
  logic [2:0]       rm_q, rm_d;
  logic             dup_c;
  logic             opd_fire_c;
  logic [2:0]       sel_onehot_c;

  // A beat whose slot is already filled must wait for the next op.
  always_comb begin
    dup_c        = 1'b0;
    sel_onehot_c = 3'b000;
    case (opd_sel_i)
      OPD_SEL_A: begin dup_c = got_q[0]; sel_onehot_c = 3'b001; end
      OPD_SEL_B: begin dup_c = got_q[1]; sel_onehot_c = 3'b010; end
      OPD_SEL_C: begin dup_c = got_q[2]; sel_onehot_c = 3'b100; end
      default:   begin dup_c = 1'b0;     sel_onehot_c = 3'b000; end
    endcase
  end

  assign opd_fire_c = opd_valid_i & opd_ready_o;

  always_comb begin
    state_d     = state_q;
    got_d       = got_q;
    err_d       = err_q;
    warp_d      = warp_q;
    idx_d       = idx_q;
    rm_d        = rm_q;
    req_ready_o = 1'b0;
    opd_ready_o = 1'b0;
    out_valid_o = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
      got_d   = 3'b000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_o = 1'b1;
          if (req_valid_i) begin
            warp_d  = req_warpid_i;
            idx_d   = req_reg_idxw_i;
            rm_d    = req_rm_i;
            got_d   = 3'b000;
            state_d = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          opd_ready_o = ~dup_c;
          if (opd_valid_i && !dup_c) begin
            if (opd_sel_i == OPD_SEL_ILL) begin
              err_d = 1'b1;
            end else begin
              got_d = got_q | sel_onehot_c;
            end
          end
          if (got_d == 3'b111) begin
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          out_valid_o = 1'b1;
          if (out_ready_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      got_q   <= 3'b000;
      err_q   <= 1'b0;
      warp_q  <= '0;
      idx_q   <= '0;
      rm_q    <= '0;
    end else begin
      state_q <= state_d;
      got_q   <= got_d;
      err_q   <= err_d;
      warp_q  <= warp_d;
      idx_q   <= idx_d;
      rm_q    <= rm_d;
    end
  end

  tc_opd_reg #(.DW(DW)) u_reg_a (
    .clk  (clk),
    .rst  (rst),
    .we_i (opd_fire_c && (opd_sel_i == OPD_SEL_A)),
    .d_i  (opd_data_i),
    .q_o  (a_o)
  );

  tc_opd_reg #(.DW(DW)) u_reg_b (
    .clk  (clk),
    .rst  (rst),
    .we_i (opd_fire_c && (opd_sel_i == OPD_SEL_B)),
    .d_i  (opd_data_i),
    .q_o  (b_o)
  );

  tc_opd_reg #(.DW(DW)) u_reg_c (
    .clk  (clk),
    .rst  (rst),
    .we_i (opd_fire_c && (opd_sel_i == OPD_SEL_C)),
    .d_i  (opd_data_i),
    .q_o  (c_o)
  );

  always_comb begin
    rm_o = '0;
    for (int k = 0; k < int'(VL); k++) begin
      rm_o[k*3 +: 3] = rm_q;
    end
  end

  assign ctrl_reg_idxw_o = idx_q;
  assign ctrl_warpid_o   = warp_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_tensor_operand_collector.sv
// Scoreboard bench for tensor_operand_collector: expected operand sets are
// queued as ops are driven and compared when the collector issues them.
module tb_tensor_operand_collector;
  import tensor_operand_collector_pkg::*;

  localparam int unsigned VL = NUM_THREAD;
  localparam int unsigned WW = DEPTH_WARP;
  localparam int unsigned DW = VL * 32;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [2:0]    rm;
    logic [WW-1:0] warp;
    logic [7:0]    idx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [WW-1:0] req_warpid_i;
  logic [7:0]    req_reg_idxw_i;
  logic [2:0]    req_rm_i;
  logic          opd_valid_i;
  logic          opd_ready_o;
  logic [1:0]    opd_sel_i;
  logic [DW-1:0] opd_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] a_o, b_o, c_o;
  logic [VL*3-1:0] rm_o;
  logic [7:0]    ctrl_reg_idxw_o;
  logic [WW-1:0] ctrl_warpid_o;
  logic          err_o;

  int   n_tot  = 0;
  int   n_bad  = 0;
  int   n_pop  = 0;
  exp_t sb[$];
  exp_t mon_e;

  tensor_operand_collector dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_warpid_i    (req_warpid_i),
    .req_reg_idxw_i  (req_reg_idxw_i),
    .req_rm_i        (req_rm_i),
    .opd_valid_i     (opd_valid_i),
    .opd_ready_o     (opd_ready_o),
    .opd_sel_i       (opd_sel_i),
    .opd_data_i      (opd_data_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .a_o             (a_o),
    .b_o             (b_o),
    .c_o             (c_o),
    .rm_o            (rm_o),
    .ctrl_reg_idxw_o (ctrl_reg_idxw_o),
    .ctrl_warpid_o   (ctrl_warpid_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VL*3-1:0] rep_rm(input logic [2:0] r);
    logic [VL*3-1:0] v;
    for (int k = 0; k < int'(VL); k++) v[k*3 +: 3] = r;
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd_vec();
    logic [DW-1:0] v;
    for (int k = 0; k < int'(VL); k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completed handshakes are scored against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexp_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("a_o", a_o, mon_e.a);
        chk("b_o", b_o, mon_e.b);
        chk("c_o", c_o, mon_e.c);
        chk("rm_o", DW'(rm_o), DW'(rep_rm(mon_e.rm)));
        chk("warpid", DW'(ctrl_warpid_o), DW'(mon_e.warp));
        chk("reg_idxw", DW'(ctrl_reg_idxw_o), DW'(mon_e.idx));
        n_pop++;
      end
    end
  end

  task automatic send_req(input logic [WW-1:0] w, input logic [7:0] idx, input logic [2:0] rm);
    bit ok = 0;
    req_valid_i = 1'b1; req_warpid_i = w; req_reg_idxw_i = idx; req_rm_i = rm;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready_o) begin ok = 1; break; end
    end
    if (!ok) chk("req_timeout", 0, 1);
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic send_beat(input logic [1:0] sel, input logic [DW-1:0] d);
    bit ok = 0;
    opd_valid_i = 1'b1; opd_sel_i = sel; opd_data_i = d;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (opd_ready_o) begin ok = 1; break; end
    end
    if (!ok) chk("beat_timeout", 0, 1);
    step();
    opd_valid_i = 1'b0;
  endtask

  task automatic wait_out();
    int start = n_pop;
    out_ready_i = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      if (n_pop > start) break;
    end
    #1;
    out_ready_i = 1'b0;
    if (n_pop == start) chk("out_timeout", 0, 1);
  endtask

  initial begin
    exp_t e;
    logic [DW-1:0] c2;
    rst = 1'b1; flush_i = 0; req_valid_i = 0; req_warpid_i = '0; req_reg_idxw_i = '0;
    req_rm_i = '0; opd_valid_i = 0; opd_sel_i = '0; opd_data_i = '0; out_ready_i = 0;

    // Reset
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", DW'(req_ready_o), 1);
    chk("rst_out_valid", DW'(out_valid_o), 0);
    chk("rst_opd_ready", DW'(opd_ready_o), 0);
    chk("rst_err", DW'(err_o), 0);
    chk("rst_a", a_o, 0);
    chk("rst_b", b_o, 0);
    chk("rst_c", c_o, 0);
    step();

    // In-order A,B,C with 1.0 in every lane
    e.a = {VL{32'h3F800000}}; e.b = e.a; e.c = e.a;
    e.rm = 3'b001; e.warp = WW'(3); e.idx = 8'h21;
    sb.push_back(e);
    send_req(e.warp, e.idx, e.rm);
    send_beat(OPD_SEL_A, e.a);
    send_beat(OPD_SEL_B, e.b);
    send_beat(OPD_SEL_C, e.c);
    @(negedge clk);
    chk("lat_out_valid", DW'(out_valid_o), 1);
    chk("lat_rm", DW'(rm_o), DW'(rep_rm(3'b001)));
    chk("lat_warp", DW'(ctrl_warpid_o), 3);
    chk("lat_idx", DW'(ctrl_reg_idxw_o), 8'h21);
    step();
    wait_out();

    // Out of order with a duplicate C that must stall
    e.a = rnd_vec(); e.b = rnd_vec(); e.c = rnd_vec(); c2 = ~e.c;
    e.rm = 3'b100; e.warp = WW'(5); e.idx = 8'h7e;
    sb.push_back(e);
    send_req(e.warp, e.idx, e.rm);
    send_beat(OPD_SEL_C, e.c);
    opd_valid_i = 1'b1; opd_sel_i = OPD_SEL_C; opd_data_i = c2;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("dup_stall", DW'(opd_ready_o), 0);
    end
    step();
    send_beat(OPD_SEL_B, e.b);
    send_beat(OPD_SEL_A, e.a);
    wait_out();

    // Backpressure in ISSUE
    e.a = rnd_vec(); e.b = rnd_vec(); e.c = rnd_vec();
    e.rm = 3'b010; e.warp = WW'(1); e.idx = 8'h05;
    sb.push_back(e);
    send_req(e.warp, e.idx, e.rm);
    send_beat(OPD_SEL_B, e.b);
    send_beat(OPD_SEL_C, e.c);
    send_beat(OPD_SEL_A, e.a);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_valid", DW'(out_valid_o), 1);
      chk("bp_a", a_o, e.a);
      chk("bp_b", b_o, e.b);
      chk("bp_c", c_o, e.c);
    end
    step();
    wait_out();
    @(negedge clk);
    chk("bp_req_ready", DW'(req_ready_o), 1);
    chk("bp_out_valid", DW'(out_valid_o), 0);
    step();

    // Illegal select during COLLECT
    e.a = rnd_vec(); e.b = rnd_vec(); e.c = rnd_vec();
    e.rm = 3'b011; e.warp = WW'(6); e.idx = 8'hc3;
    sb.push_back(e);
    send_req(e.warp, e.idx, e.rm);
    send_beat(OPD_SEL_A, e.a);
    send_beat(OPD_SEL_ILL, rnd_vec());
    @(negedge clk);
    chk("ill_err", DW'(err_o), 1);
    chk("ill_no_issue", DW'(out_valid_o), 0);
    chk("ill_b_ready", DW'((opd_sel_i == OPD_SEL_ILL) ? opd_ready_o : 1'b1), 1);
    step();
    send_beat(OPD_SEL_B, e.b);
    send_beat(OPD_SEL_C, e.c);
    wait_out();
    chk("ill_err_sticky", DW'(err_o), 1);

    // Flush during COLLECT, then flush during ISSUE
    send_req(WW'(2), 8'h11, 3'b000);
    send_beat(OPD_SEL_A, rnd_vec());
    send_beat(OPD_SEL_B, rnd_vec());
    flush_i = 1'b1; opd_valid_i = 1'b1; opd_sel_i = OPD_SEL_C;
    @(negedge clk);
    chk("fl_opd_ready", DW'(opd_ready_o), 0);
    chk("fl_req_ready", DW'(req_ready_o), 0);
    step();
    flush_i = 1'b0; opd_valid_i = 1'b0;
    @(negedge clk);
    chk("fl_idle", DW'(req_ready_o), 1);
    step();
    send_req(WW'(4), 8'h22, 3'b111);
    send_beat(OPD_SEL_A, rnd_vec());
    send_beat(OPD_SEL_B, rnd_vec());
    send_beat(OPD_SEL_C, rnd_vec());
    flush_i = 1'b1; out_ready_i = 1'b1;
    @(negedge clk);
    chk("fl_out_valid", DW'(out_valid_o), 0);
    step();
    flush_i = 1'b0; out_ready_i = 1'b0;
    @(negedge clk);
    chk("fl2_idle", DW'(req_ready_o), 1);
    chk("fl2_out_valid", DW'(out_valid_o), 0);
    chk("fl_err_kept", DW'(err_o), 1);
    step();

    // Fresh op after flushes
    e.a = rnd_vec(); e.b = rnd_vec(); e.c = rnd_vec();
    e.rm = 3'b101; e.warp = WW'(7); e.idx = 8'hff;
    sb.push_back(e);
    send_req(e.warp, e.idx, e.rm);
    send_beat(OPD_SEL_C, e.c);
    send_beat(OPD_SEL_A, e.a);
    send_beat(OPD_SEL_B, e.b);
    wait_out();

    chk("sb_empty", DW'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
